uart_frame_scheduler: RTL and testbench

- Sequences the byte-serial UART transmitter on behalf of two sensor sources, temperature and light.
- Captures each source's 8-bit sample and arbitrates round-robin between sources.
- Wraps the granted sample in a 4-byte frame: sync, channel id, data, checksum.
- Feeds the frame to the transmitter one byte at a time over a tx_start/tx_busy handshake, with a timeout and an inter-frame gap.
- Sits between the ADC interface and the UART transmitter.

---
 rtl/uart_frame_pkg.sv | 23 ++
 rtl/sample_slot.sv | 31 +++
 rtl/uart_frame_scheduler.sv | 148 ++++++++++++++
 tb/tb_uart_frame_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame scheduler: frame bytes, channel ids,
// FSM state encoding and the frame checksum helper.
package uart_frame_pkg;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam logic [7:0] CH_ID_TEMP  = 8'h01;
   localparam logic [7:0] CH_ID_LIGHT = 8'h02;
   localparam int         FRAME_LEN   = 4;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SEND      = 3'd1;
   localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_GAP       = 3'd4;

   localparam logic TEMP  = 1'b0;
   localparam logic LIGHT = 1'b1;

   function automatic logic [7:0] frame_checksum(input logic [7:0] id, input logic [7:0] sample);
      return SYNC_BYTE ^ id ^ sample;
   endfunction

endpackage

// File: rtl/sample_slot.sv
// One-deep holding slot for a sensor sample: newest sample wins, and an
// overwrite of an unsent sample is flagged with a one-cycle drop pulse.
module sample_slot (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid,
   input  logic [7:0] data,
   input  logic       grant,
   output logic       pending,
   output logic [7:0] sample,
   output logic       drop
);

   // A valid coinciding with grant refills the slot after the old value was taken, so it is not a drop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= 1'b0;
         sample  <= 8'h00;
         drop    <= 1'b0;
      end else begin
         drop <= valid & pending & ~grant;
         if (valid) begin
            sample  <= data;
            pending <= 1'b1;
         end else if (grant) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Round-robin scheduler that frames temperature/light samples and feeds them
// byte by byte to a UART transmitter over a tx_start/tx_busy handshake.
module uart_frame_scheduler
   import uart_frame_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16,
   parameter int GAP_CYCLES  = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             temp_valid,
   input  logic [7:0]       temp_data,
   input  logic             light_valid,
   input  logic [7:0]       light_data,
   input  logic             tx_busy,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   output logic             frame_active,
   output logic             temp_drop,
   output logic             light_drop,
   output logic [CNT_W-1:0] frame_count
);

   localparam int             ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int             GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [1:0]     LAST_IDX = 2'(FRAME_LEN - 1);

   logic [2:0]       state, next_state;
   logic             temp_pending, light_pending;
   logic [7:0]       temp_sample, light_sample;
   logic             grant_temp, grant_light;
   logic             last_grant;
   logic [7:0]       frame_id, frame_sample;
   logic [1:0]       byte_idx;
   logic [ACK_W-1:0] ack_cnt;
   logic [GAP_W-1:0] gap_cnt;

   sample_slot u_temp_slot (
      .clk     (clk),
      .rst     (rst),
      .valid   (temp_valid),
      .data    (temp_data),
      .grant   (grant_temp),
      .pending (temp_pending),
      .sample  (temp_sample),
      .drop    (temp_drop)
   );

   sample_slot u_light_slot (
      .clk     (clk),
      .rst     (rst),
      .valid   (light_valid),
      .data    (light_data),
      .grant   (grant_light),
      .pending (light_pending),
      .sample  (light_sample),
      .drop    (light_drop)
   );

   // On a tie the channel that was not served last goes next.
   always_comb begin
      grant_temp  = 1'b0;
      grant_light = 1'b0;
      if (state == ST_IDLE) begin
         if (temp_pending && light_pending) begin
            if (last_grant == LIGHT) grant_temp = 1'b1;
            else                     grant_light = 1'b1;
         end else if (temp_pending) begin
            grant_temp = 1'b1;
         end else if (light_pending) begin
            grant_light = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:      if (grant_temp || grant_light) next_state = ST_SEND;
         ST_SEND:      next_state = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (tx_busy)                  next_state = ST_WAIT_DONE;
            else if (ack_cnt == ACK_LAST) next_state = ST_SEND;
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               if (byte_idx != LAST_IDX)  next_state = ST_SEND;
               else if (GAP_CYCLES > 0)   next_state = ST_GAP;
               else                       next_state = ST_IDLE;
            end
         end
         ST_GAP:       if (gap_cnt == GAP_LAST) next_state = ST_IDLE;
         default:      next_state = ST_IDLE;
      endcase
   end

   // Frame registers are latched at grant so later samples cannot disturb a frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant   <= LIGHT;
         frame_id     <= 8'h00;
         frame_sample <= 8'h00;
         byte_idx     <= 2'd0;
         ack_cnt      <= '0;
         gap_cnt      <= '0;
         frame_count  <= '0;
      end else begin
         if (grant_temp || grant_light) begin
            last_grant   <= grant_light ? LIGHT : TEMP;
            frame_id     <= grant_light ? CH_ID_LIGHT : CH_ID_TEMP;
            frame_sample <= grant_light ? light_sample : temp_sample;
            byte_idx     <= 2'd0;
         end
         if (state == ST_SEND)                      ack_cnt <= '0;
         else if (state == ST_WAIT_ACK && !tx_busy) ack_cnt <= ack_cnt + ACK_W'(1);
         if (state == ST_WAIT_DONE && !tx_busy) begin
            gap_cnt <= '0;
            if (byte_idx == LAST_IDX) frame_count <= frame_count + CNT_W'(1);
            else                      byte_idx    <= byte_idx + 2'd1;
         end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
         end
      end
   end

   always_comb begin
      tx_start     = (state == ST_SEND);
      frame_active = (state != ST_IDLE);
      tx_data      = 8'h00;
      if (state == ST_SEND || state == ST_WAIT_ACK || state == ST_WAIT_DONE) begin
         case (byte_idx)
            2'd0:    tx_data = SYNC_BYTE;
            2'd1:    tx_data = frame_id;
            2'd2:    tx_data = frame_sample;
            default: tx_data = frame_checksum(frame_id, frame_sample);
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler with a UART transmitter model and a
// byte scoreboard filled when samples are driven and drained on each tx_start.
module tb_uart_frame_scheduler;

   localparam int ACK_TIMEOUT = 16;
   localparam int GAP_CYCLES  = 5;
   localparam int CNT_W       = 16;
   localparam int BUSY_HOLD   = 20;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             temp_valid = 1'b0;
   logic [7:0]       temp_data = 8'h00;
   logic             light_valid = 1'b0;
   logic [7:0]       light_data = 8'h00;
   logic             tx_busy;
   logic             tx_start;
   logic [7:0]       tx_data;
   logic             frame_active;
   logic             temp_drop;
   logic             light_drop;
   logic [CNT_W-1:0] frame_count;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   logic [7:0] expected_q[$];
   int  ignore_cnt = 0;
   int  temp_drops = 0;
   int  light_drops = 0;
   int  start_cnt = 0;
   int  idle_run = 0;
   int  sync_idle = -1;
   int  data_idle = -1;
   int  retry_idle = -1;
   bit  prev_ignored = 1'b0;
   bit  raise_next = 1'b0;
   int  busy_left = 0;

   always #5 clk = ~clk;

   uart_frame_scheduler #(
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .GAP_CYCLES  (GAP_CYCLES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .temp_valid   (temp_valid),
      .temp_data    (temp_data),
      .light_valid  (light_valid),
      .light_data   (light_data),
      .tx_busy      (tx_busy),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .frame_active (frame_active),
      .temp_drop    (temp_drop),
      .light_drop   (light_drop),
      .frame_count  (frame_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic void pushFrame(input logic [7:0] id, input logic [7:0] sample);
      expected_q.push_back(8'hA5);
      expected_q.push_back(id);
      expected_q.push_back(sample);
      expected_q.push_back(8'hA5 ^ id ^ sample);
   endfunction

   task automatic applyStimulus(input logic tv, input logic [7:0] td, input logic lv, input logic [7:0] ld);
      temp_valid  = tv;
      temp_data   = td;
      light_valid = lv;
      light_data  = ld;
      @(negedge clk);
      temp_valid  = 1'b0;
      light_valid = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (expected_q.size() == 0 && !frame_active) done = 1'b1;
      end
      checkOutput("frame_done", 32'(done), 32'd1);
   endtask

   // Transmitter model: busy rises the cycle after an accepted tx_start and holds for BUSY_HOLD cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            tx_busy      = 1'b0;
            busy_left    = 0;
            raise_next   = 1'b0;
            idle_run     = 0;
            prev_ignored = 1'b0;
         end else begin
            if (temp_drop)  temp_drops++;
            if (light_drop) light_drops++;
            if (busy_left > 0) begin
               busy_left--;
               if (busy_left == 0) tx_busy = 1'b0;
            end else if (raise_next) begin
               tx_busy    = 1'b1;
               busy_left  = BUSY_HOLD;
               raise_next = 1'b0;
            end
            if (tx_start) begin
               start_cnt++;
               checkOutput("start_while_busy", 32'(tx_busy), 32'd0);
               checkOutput("start_expected", 32'(expected_q.size() != 0), 32'd1);
               if (expected_q.size() != 0) begin
                  if (prev_ignored)                  retry_idle = idle_run;
                  else if (expected_q.size() % 4 == 0) sync_idle = idle_run;
                  else                               data_idle = idle_run;
                  checkOutput("tx_byte", 32'(tx_data), 32'(expected_q[0]));
                  if (ignore_cnt > 0) begin
                     ignore_cnt--;
                     prev_ignored = 1'b1;
                  end else begin
                     void'(expected_q.pop_front());
                     raise_next   = 1'b1;
                     prev_ignored = 1'b0;
                  end
               end
               idle_run = 0;
            end else if (tx_busy) begin
               idle_run = 0;
            end else begin
               idle_run++;
            end
         end
      end
   end

   initial begin
      int temp_base;
      int light_base;
      int start_base;
      bit hit;
      $display("[TB] uart_frame_scheduler bench starting");

      repeat (3) @(negedge clk);
      checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
      checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
      checkOutput("rst_frame_active", 32'(frame_active), 32'd0);
      checkOutput("rst_temp_drop", 32'(temp_drop), 32'd0);
      checkOutput("rst_light_drop", 32'(light_drop), 32'd0);
      checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single temperature frame: A5 01 3C 98.
      pushFrame(8'h01, 8'h3C);
      applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("active_in_frame", 32'(frame_active), 32'd1);
      waitIdle(2000);
      checkOutput("count_after_one", 32'(frame_count), 32'd1);

      // Fresh reset so temperature wins the tie, then both channels in one cycle.
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      temp_base  = temp_drops;
      light_base = light_drops;
      pushFrame(8'h01, 8'h10);
      pushFrame(8'h02, 8'h20);
      applyStimulus(1'b1, 8'h10, 1'b1, 8'h20);
      waitIdle(4000);
      checkOutput("count_after_pair", 32'(frame_count), 32'd2);
      checkOutput("pair_temp_drops", 32'(temp_drops - temp_base), 32'd0);
      checkOutput("pair_light_drops", 32'(light_drops - light_base), 32'd0);
      checkOutput("inter_frame_gap", 32'(sync_idle), 32'(GAP_CYCLES + 2));
      checkOutput("intra_frame_gap", 32'(data_idle), 32'd1);

      // Three light samples during a temperature frame: two overwrites, newest sent.
      temp_base  = temp_drops;
      light_base = light_drops;
      pushFrame(8'h01, 8'h44);
      applyStimulus(1'b1, 8'h44, 1'b0, 8'h00);
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h01);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h02);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h03);
      pushFrame(8'h02, 8'h03);
      waitIdle(4000);
      checkOutput("light_drops", 32'(light_drops - light_base), 32'd2);
      checkOutput("temp_drops", 32'(temp_drops - temp_base), 32'd0);
      checkOutput("count_after_drop", 32'(frame_count), 32'd4);

      // Transmitter ignores the first tx_start; the sync byte must be re-pulsed.
      ignore_cnt = 1;
      pushFrame(8'h01, 8'h55);
      applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
      waitIdle(4000);
      checkOutput("retry_wait", 32'(retry_idle), 32'(ACK_TIMEOUT));
      checkOutput("count_after_retry", 32'(frame_count), 32'd5);

      // Reset while byte 2 is on the wire, with a light sample also pending.
      pushFrame(8'h01, 8'h77);
      applyStimulus(1'b1, 8'h77, 1'b0, 8'h00);
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h99);
      hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(negedge clk);
         if (expected_q.size() == 1 && tx_busy) hit = 1'b1;
      end
      checkOutput("reached_byte2", 32'(hit), 32'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("mid_tx_start", 32'(tx_start), 32'd0);
      checkOutput("mid_tx_data", 32'(tx_data), 32'd0);
      checkOutput("mid_frame_active", 32'(frame_active), 32'd0);
      checkOutput("mid_temp_drop", 32'(temp_drop), 32'd0);
      checkOutput("mid_light_drop", 32'(light_drop), 32'd0);
      checkOutput("mid_frame_count", 32'(frame_count), 32'd0);
      expected_q.delete();
      repeat (2) @(negedge clk);
      start_base = start_cnt;
      rst = 1'b1;
      repeat (100) @(negedge clk);
      checkOutput("no_start_after_rst", 32'(start_cnt - start_base), 32'd0);
      pushFrame(8'h02, 8'h5A);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h5A);
      waitIdle(2000);
      checkOutput("count_after_restart", 32'(frame_count), 32'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
